// File: rtl/input_conditioner_if.sv
// Signal bundle between the raw board inputs and the multiplier-facing
// conditioned outputs of input_conditioner.
interface input_conditioner_if;
  logic       Run_btn;
  logic       Load_btn;
  logic [7:0] SW_raw;
  logic       Run;
  logic       Run_rise;
  logic       Run_fall;
  logic       Reset_Load_Clear;
  logic       Load_rise;
  logic [7:0] SW;

  modport master (
    output Run_btn, Load_btn, SW_raw,
    input  Run, Run_rise, Run_fall, Reset_Load_Clear, Load_rise, SW
  );

  modport slave (
    input  Run_btn, Load_btn, SW_raw,
    output Run, Run_rise, Run_fall, Reset_Load_Clear, Load_rise, SW
  );
endinterface

// File: rtl/input_conditioner.sv
// Pushbutton/switch front end: two-flop synchronisers on every raw input and
// a 4-state debounce FSM per button producing a level plus registered edge pulses.
module input_conditioner_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_W           = 24
) (
  input  logic Clk,
  input  logic Reset,
  input  logic i_raw,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);
  typedef enum logic [1:0] {S_LOW, W_HIGH, S_HIGH, W_LOW} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_f1, r_f2;
  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_level, w_level_nxt;
  logic             r_rise, w_rise_nxt;
  logic             r_fall, w_fall_nxt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_f1    <= 1'b0;
      r_f2    <= 1'b0;
      r_state <= S_LOW;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_f1    <= i_raw;
      r_f2    <= r_f1;
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_level <= w_level_nxt;
      r_rise  <= w_rise_nxt;
      r_fall  <= w_fall_nxt;
    end
  end

  // NOTE: every output of this block gets a default first, so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_level_nxt = r_level;
    w_rise_nxt  = 1'b0;
    w_fall_nxt  = 1'b0;
    case (r_state)
      S_LOW: begin
        if (r_f2) begin
          w_state_nxt = W_HIGH;
          w_cnt_nxt   = CNT_W'(1);
        end
      end
      W_HIGH: begin
        if (!r_f2) begin
          w_state_nxt = S_LOW;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = S_HIGH;
          w_cnt_nxt   = '0;
          w_level_nxt = 1'b1;
          w_rise_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_HIGH: begin
        if (!r_f2) begin
          w_state_nxt = W_LOW;
          w_cnt_nxt   = CNT_W'(1);
        end
      end
      W_LOW: begin
        if (r_f2) begin
          w_state_nxt = S_HIGH;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = S_LOW;
          w_cnt_nxt   = '0;
          w_level_nxt = 1'b0;
          w_fall_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = S_LOW;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign o_level = r_level;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;
endmodule

module input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_W           = 24
) (
  input  logic                Clk,
  input  logic                Reset,
  input_conditioner_if.slave  bus
);
  logic [7:0] r_sw_f1, r_sw_f2;
  logic       w_unused_load_fall;

  // Switches are static operands, so synchronisation alone is enough.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_sw_f1 <= '0;
      r_sw_f2 <= '0;
    end else begin
      r_sw_f1 <= bus.SW_raw;
      r_sw_f2 <= r_sw_f1;
    end
  end

  input_conditioner_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_run_db (
    .Clk    (Clk),
    .Reset  (Reset),
    .i_raw  (bus.Run_btn),
    .o_level(bus.Run),
    .o_rise (bus.Run_rise),
    .o_fall (bus.Run_fall)
  );

  input_conditioner_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_load_db (
    .Clk    (Clk),
    .Reset  (Reset),
    .i_raw  (bus.Load_btn),
    .o_level(bus.Reset_Load_Clear),
    .o_rise (bus.Load_rise),
    .o_fall (w_unused_load_fall)
  );

  assign bus.SW = r_sw_f2;
endmodule

// File: tb/tb_input_conditioner.sv
// Directed and randomized bench for input_conditioner; a sliding-window
// reference model predicts levels, pulses and synchronised switches.
module tb_input_conditioner;
  localparam int D = 4;

  logic Clk = 1'b0;
  logic Reset;

  input_conditioner_if u_if();

  input_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .CNT_W          (3)
  ) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .bus  (u_if.slave)
  );

  always #5 Clk = ~Clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Raw value seen at each of the last D+2 edges; index 0 is the newest.
  bit       h_run [D+2];
  bit       h_load[D+2];
  bit [7:0] h_sw  [D+2];
  bit       m_run, m_load, m_run_rise, m_run_fall, m_load_rise;
  int       run_rises, run_falls, load_rises;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_clear();
    for (int i = 0; i < D + 2; i++) begin
      h_run[i] = 1'b0; h_load[i] = 1'b0; h_sw[i] = 8'h00;
    end
    m_run = 1'b0; m_load = 1'b0;
    m_run_rise = 1'b0; m_run_fall = 1'b0; m_load_rise = 1'b0;
  endfunction

  // A level flips once the D samples the FSM has seen all hold the new value;
  // the FSM sees each raw value two edges after it is presented.
  function automatic bit window_all(input bit h[D+2], input bit v);
    bit ok = 1'b1;
    for (int i = 2; i < D + 2; i++) if (h[i] != v) ok = 1'b0;
    return ok;
  endfunction

  task automatic model_edge();
    if (Reset) begin
      model_clear();
      return;
    end
    for (int i = D + 1; i > 0; i--) begin
      h_run[i] = h_run[i-1]; h_load[i] = h_load[i-1]; h_sw[i] = h_sw[i-1];
    end
    h_run[0] = u_if.Run_btn; h_load[0] = u_if.Load_btn; h_sw[0] = u_if.SW_raw;
    m_run_rise  = !m_run  && window_all(h_run, 1'b1);
    m_run_fall  =  m_run  && window_all(h_run, 1'b0);
    m_load_rise = !m_load && window_all(h_load, 1'b1);
    if (m_run_rise) m_run = 1'b1;
    if (m_run_fall) m_run = 1'b0;
    if (m_load_rise) m_load = 1'b1;
    else if (m_load && window_all(h_load, 1'b0)) m_load = 1'b0;
  endtask

  task automatic check_outputs();
    chk("Run",              {7'd0, u_if.Run},              {7'd0, m_run});
    chk("Run_rise",         {7'd0, u_if.Run_rise},         {7'd0, m_run_rise});
    chk("Run_fall",         {7'd0, u_if.Run_fall},         {7'd0, m_run_fall});
    chk("Reset_Load_Clear", {7'd0, u_if.Reset_Load_Clear}, {7'd0, m_load});
    chk("Load_rise",        {7'd0, u_if.Load_rise},        {7'd0, m_load_rise});
    chk("SW",               u_if.SW,                       h_sw[1]);
  endtask

  task automatic tick();
    @(posedge Clk);
    model_edge();
    #1;
    check_outputs();
    if (u_if.Run_rise)  run_rises++;
    if (u_if.Run_fall)  run_falls++;
    if (u_if.Load_rise) load_rises++;
  endtask

  task automatic set_reset(input logic on);
    Reset = on;
    if (on) model_clear();
  endtask

  task automatic clear_counts();
    run_rises = 0; run_falls = 0; load_rises = 0;
  endtask

  task automatic fresh_start();
    set_reset(1'b1);
    u_if.Run_btn = 1'b0; u_if.Load_btn = 1'b0; u_if.SW_raw = 8'h00;
    repeat (2) tick();
    set_reset(1'b0);
    repeat (8) tick();
    clear_counts();
  endtask

  initial begin
    int run_hold, load_hold;
    model_clear();
    clear_counts();

    // 1. Reset sanity with button held and switches set
    set_reset(1'b1);
    u_if.Run_btn = 1'b1; u_if.Load_btn = 1'b0; u_if.SW_raw = 8'hA5;
    #1;
    chk("s1_run_in_reset", {7'd0, u_if.Run}, 8'h00);
    chk("s1_sw_in_reset",  u_if.SW,          8'h00);
    repeat (3) tick();
    set_reset(1'b0);
    for (int e = 1; e <= 8; e++) begin
      tick();
      if (e == 1) chk("s1_sw_edge1",  u_if.SW, 8'h00);
      if (e == 2) chk("s1_sw_edge2",  u_if.SW, 8'hA5);
      if (e == 5) chk("s1_run_edge5", {7'd0, u_if.Run}, 8'h00);
      if (e == 6) chk("s1_rise_edge6", {6'd0, u_if.Run, u_if.Run_rise}, 8'h03);
      if (e == 7) chk("s1_rise_edge7", {6'd0, u_if.Run, u_if.Run_rise}, 8'h02);
    end

    // 2. Clean press and release
    fresh_start();
    u_if.Run_btn = 1'b1;
    for (int e = 1; e <= D + 2; e++) begin
      tick();
      if (e == D + 1) chk("s2_run_before", {7'd0, u_if.Run}, 8'h00);
      if (e == D + 2) chk("s2_rise", {6'd0, u_if.Run, u_if.Run_rise}, 8'h03);
    end
    repeat (14) tick();
    u_if.Run_btn = 1'b0;
    for (int e = 1; e <= D + 2; e++) begin
      tick();
      if (e == D + 1) chk("s2_run_hold", {7'd0, u_if.Run}, 8'h01);
      if (e == D + 2) chk("s2_fall", {6'd0, u_if.Run, u_if.Run_fall}, 8'h01);
    end
    repeat (4) tick();
    chk("s2_pulse_counts", 8'(run_rises * 16 + run_falls * 4 + load_rises), 8'h14);

    // 3. Bounce rejection: 1,0,1,0 for 2 cycles each, then settle high
    fresh_start();
    for (int b = 0; b < 4; b++) begin
      u_if.Run_btn = (b % 2 == 0);
      repeat (2) begin
        tick();
        chk("s3_run_bounce", {7'd0, u_if.Run}, 8'h00);
      end
    end
    u_if.Run_btn = 1'b1;
    for (int e = 1; e <= D + 2; e++) begin
      tick();
      if (e == D + 1) chk("s3_run_before", {7'd0, u_if.Run}, 8'h00);
      if (e == D + 2) chk("s3_rise", {6'd0, u_if.Run, u_if.Run_rise}, 8'h03);
    end
    repeat (6) tick();
    chk("s3_rise_count", 8'(run_rises), 8'd1);

    // 4. Short Load glitch rejected, full-length pulse accepted
    fresh_start();
    u_if.Load_btn = 1'b1;
    repeat (D - 1) tick();
    u_if.Load_btn = 1'b0;
    repeat (10) tick();
    chk("s4_glitch_level", {7'd0, u_if.Reset_Load_Clear}, 8'h00);
    chk("s4_glitch_rises", 8'(load_rises), 8'd0);
    u_if.Load_btn = 1'b1;
    repeat (D) tick();
    u_if.Load_btn = 1'b0;
    repeat (10) tick();
    chk("s4_pulse_rises", 8'(load_rises), 8'd1);

    // 5. Reset mid-debounce discards progress
    fresh_start();
    u_if.Run_btn = 1'b1;
    repeat (3) tick();
    set_reset(1'b1);
    #1;
    chk("s5_run_in_reset", {7'd0, u_if.Run}, 8'h00);
    repeat (4) tick();
    set_reset(1'b0);
    for (int e = 1; e <= D + 2; e++) begin
      tick();
      if (e == D + 1) chk("s5_run_before", {7'd0, u_if.Run}, 8'h00);
      if (e == D + 2) chk("s5_run_after", {7'd0, u_if.Run}, 8'h01);
    end

    // 6. Simultaneous presses and switch change
    fresh_start();
    u_if.Run_btn = 1'b1; u_if.Load_btn = 1'b1; u_if.SW_raw = 8'hFF;
    for (int e = 1; e <= D + 2; e++) begin
      tick();
      if (e == 1) chk("s6_sw_edge1", u_if.SW, 8'h00);
      if (e == 2) chk("s6_sw_edge2", u_if.SW, 8'hFF);
      if (e == D + 2) chk("s6_both_rise", {6'd0, u_if.Run_rise, u_if.Load_rise}, 8'h03);
    end

    // Randomized bouncy buttons, switch changes and occasional resets
    run_hold = 0; load_hold = 0;
    for (int c = 0; c < 3000; c++) begin
      if (run_hold == 0) begin
        u_if.Run_btn = ~u_if.Run_btn;
        run_hold = $urandom_range(1, 2 * D + 2);
      end
      if (load_hold == 0) begin
        u_if.Load_btn = ~u_if.Load_btn;
        load_hold = $urandom_range(1, 2 * D + 2);
      end
      if ($urandom_range(0, 7) == 0) u_if.SW_raw = 8'($urandom);
      if ($urandom_range(0, 299) == 0) set_reset(1'b1);
      else if (Reset && $urandom_range(0, 2) == 0) set_reset(1'b0);
      run_hold--; load_hold--;
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
